// File: rtl/capture_pkg.sv
// Shared types for the capture engine: FSM states, trigger modes
// and the default sample RAM depth.
package capture_pkg;

  localparam int DEF_DEPTH = 512;

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    ARMED,
    POST,
    DUMP_RD,
    DUMP_HOLD
  } cap_state_e;

  typedef enum logic [1:0] {
    TRIG_OFF  = 2'b00,
    TRIG_RISE = 2'b01,
    TRIG_FALL = 2'b10,
    TRIG_AUTO = 2'b11
  } trig_type_e;

endpackage

// File: rtl/capture_decimator.sv
// Sample decimator: keeps one of every 2**dec_pwr ADC strobes,
// restarting its count whenever a capture is started.
module capture_decimator #(
  parameter int DEC_W = 4,
  localparam int CW = 2 ** DEC_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             smpl_vld,
  input  logic [DEC_W-1:0] dec_pwr,
  output logic             keep
);

  logic [CW-1:0] dec_cnt;
  logic [CW-1:0] lim;

  assign lim  = (CW'(1) << dec_pwr) - CW'(1);
  assign keep = smpl_vld & (dec_cnt == lim);

  // strobe counter: wraps on the kept strobe, cleared on capture start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dec_cnt <= '0;
    end else if (clr) begin
      dec_cnt <= '0;
    end else if (keep) begin
      dec_cnt <= '0;
    end else if (smpl_vld) begin
      dec_cnt <= dec_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/capture_engine.sv
// Single-clock capture/dump controller for the sample RAMs.
// Optional: CAPTURE_AUTOROLL_EN enables trig_type 11 (autoroll).
module capture_engine
  import capture_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW    = $clog2(DEPTH),
  parameter int NCH   = 3,
  parameter int DEC_W = 4,
  localparam int SW   = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             smpl_vld,
  input  logic [NCH-1:0]   trig_in,
  input  logic [SW-1:0]    trig_src,
  input  logic [1:0]       trig_type,
  input  logic [AW-1:0]    trig_pos,
  input  logic [DEC_W-1:0] dec_pwr,
  input  logic             start_cap,
  input  logic             abort,
  input  logic             start_dump,
  input  logic             dump_rdy,
  output logic             ram_we,
  output logic             ram_re,
  output logic [AW-1:0]    ram_addr,
  output logic             dump_vld,
  output logic             dump_last,
  output logic             armed,
  output logic             triggered,
  output logic             cap_done,
  output logic             busy
);

  localparam logic [AW:0] ONE     = (AW+1)'(1);
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  cap_state_e    state, nxt;
  trig_type_e    tt;
  logic [AW-1:0] wr_ptr, rd_ptr, trace_start;
  logic [AW:0]   pre_cnt, post_cnt, beats;
  logic [AW:0]   tp, pre_thr;
  logic          prev_sel, armed_q, trig_q, done_q;
  logic          keep, sel, type_ok, trig_hit;
  logic          capturing, wr_en, cap_go, dump_go;
  logic          pre_hit, fire, fin, acc, last_beat;

  capture_decimator #(.DEC_W(DEC_W)) u_dec (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (cap_go),
    .smpl_vld (smpl_vld),
    .dec_pwr  (dec_pwr),
    .keep     (keep)
  );

  assign tt      = trig_type_e'(trig_type);
  assign sel     = trig_in[trig_src];
  assign tp      = (trig_pos == '0) ? ONE : {1'b0, trig_pos};
  assign pre_thr = DEPTH_W - tp;

`ifdef CAPTURE_AUTOROLL_EN
  assign type_ok = (tt != TRIG_OFF);
`else
  assign type_ok = (tt == TRIG_RISE) || (tt == TRIG_FALL);
`endif

  // trigger condition on the selected channel, judged per kept sample
  always_comb begin
    trig_hit = 1'b0;
    case (tt)
      TRIG_RISE: trig_hit = sel & ~prev_sel;
      TRIG_FALL: trig_hit = ~sel & prev_sel;
`ifdef CAPTURE_AUTOROLL_EN
      TRIG_AUTO: trig_hit = 1'b1;
`endif
      default:   trig_hit = 1'b0;
    endcase
  end

  assign capturing = (state == PRE) | (state == ARMED) | (state == POST);
  assign wr_en     = keep & capturing & ~abort;
  assign dump_go   = (state == IDLE) & ~abort & start_dump & done_q;
  assign cap_go    = (state == IDLE) & ~abort & ~dump_go
                   & start_cap & type_ok;
  assign pre_hit   = wr_en & (state == PRE) & (pre_cnt + ONE >= pre_thr);
  assign fire      = wr_en & (state == ARMED) & trig_hit;
  assign fin       = (fire & (tp == ONE))
                   | (wr_en & (state == POST) & (post_cnt + ONE >= tp));
  assign acc       = (state == DUMP_HOLD) & dump_rdy & ~abort;
  assign last_beat = (beats == DEPTH_W - ONE);

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  // next-state decode; abort always returns to idle
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: begin
        if (dump_go)     nxt = DUMP_RD;
        else if (cap_go) nxt = PRE;
      end
      PRE:       if (pre_hit) nxt = ARMED;
      ARMED: begin
        if (fin)       nxt = IDLE;
        else if (fire) nxt = POST;
      end
      POST:      if (fin) nxt = IDLE;
      DUMP_RD:   nxt = DUMP_HOLD;
      DUMP_HOLD: if (acc) nxt = last_beat ? IDLE : DUMP_RD;
      default:   nxt = IDLE;
    endcase
    if (abort) nxt = IDLE;
  end

  // RAM and handshake outputs from state and qualified events
  always_comb begin
    ram_we    = wr_en;
    ram_re    = (state == DUMP_RD);
    dump_vld  = (state == DUMP_HOLD) & ~abort;
    dump_last = (state == DUMP_HOLD) & ~abort & last_beat;
    busy      = (state != IDLE);
    ram_addr  = ((state == DUMP_RD) || (state == DUMP_HOLD))
              ? rd_ptr : wr_ptr;
  end

  // pointers, counters and sticky status flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      trace_start <= '0;
      pre_cnt     <= '0;
      post_cnt    <= '0;
      beats       <= '0;
      prev_sel    <= 1'b0;
      armed_q     <= 1'b0;
      trig_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      if (cap_go) begin
        pre_cnt  <= '0;
        post_cnt <= '0;
        prev_sel <= 1'b0;
        done_q   <= 1'b0;
      end
      if (wr_en) begin
        wr_ptr   <= wr_ptr + AW'(1);
        prev_sel <= sel;
      end
      if (wr_en && state == PRE)  pre_cnt  <= pre_cnt + ONE;
      if (wr_en && state == POST) post_cnt <= post_cnt + ONE;
      if (pre_hit) armed_q <= 1'b1;
      if (fire) begin
        trig_q   <= 1'b1;
        post_cnt <= ONE;
      end
      if (fin) begin
        done_q      <= 1'b1;
        armed_q     <= 1'b0;
        trig_q      <= 1'b0;
        trace_start <= wr_ptr + AW'(1);
      end
      if (abort) begin
        armed_q <= 1'b0;
        trig_q  <= 1'b0;
      end
      if (dump_go) begin
        rd_ptr <= trace_start;
        beats  <= '0;
      end
      if (acc) begin
        rd_ptr <= rd_ptr + AW'(1);
        beats  <= beats + ONE;
      end
    end
  end

  assign armed     = armed_q;
  assign triggered = trig_q;
  assign cap_done  = done_q;

endmodule
